// File: rtl/adder_b_sequencer_pkg.sv
// Shared types and constants for the adiabatic adder sequencer slice.
// Latency: none (declarations only).
// Backpressure: not applicable.
package adiabatic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } seq_state_t;

    localparam int ADDER_WIDTH   = 16;
    localparam int BENNETT_WIDTH = 8;

endpackage

// File: rtl/adder_b_sequencer_edge.sv
// Registers adder calculation_done and produces a one-cycle rising-edge pulse.
// Latency: pulse is combinational against the previous-cycle level (one register).
// Backpressure: none; samples every cycle regardless of sequencer state.
module done_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic adder_done,
    output logic done_rise
);

    logic done_q;

    // Track the previous level of done on every cycle so WAIT entry never sees a stale edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            done_q <= 1'b0;
        end else begin
            done_q <= adder_done;
        end
    end

    assign done_rise = adder_done & ~done_q;

endmodule

// File: rtl/adder_b_sequencer.sv
// Holds operands on the Bennett-clocked adder and captures the result after a fresh done edge.
// Latency: accept->operands 1 cycle; qualifying done edge->res_valid 1 cycle; watchdog abort at TIMEOUT.
// Backpressure: in_ready only in IDLE; result held in HOLD until res_ready, new requests stalled.
module adder_b_sequencer
    import adiabatic_pkg::*;
#(
    parameter int WIDTH      = ADDER_WIDTH,
    parameter int SKIP_EDGES = 1,
    parameter int TIMEOUT    = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic [WIDTH-1:0] adder_a,
    output logic [WIDTH-1:0] adder_b,
    output logic             adder_cin,
    input  logic [WIDTH-1:0] adder_out,
    input  logic             adder_cout,
    input  logic             adder_done,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             busy,
    output logic             timeout_err
);

    localparam int EDGE_W = $clog2(SKIP_EDGES + 2);
    localparam int WD_W   = $clog2(TIMEOUT);

    // Edge count at which the capture happens (earlier edges may be from a stale Bennett cycle).
    localparam logic [EDGE_W-1:0] SKIP_CNT = EDGE_W'(SKIP_EDGES);
    // Watchdog value whose increment would reach TIMEOUT-1: abort lands exactly TIMEOUT cycles after accept.
    localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(TIMEOUT - 2);

    seq_state_t         state;
    logic [EDGE_W-1:0]  edge_cnt;
    logic [WD_W-1:0]    wd_cnt;
    logic               done_rise;
    logic               qual_edge;

    done_edge_detect u_edge (
        .clk        (clk),
        .reset      (reset),
        .adder_done (adder_done),
        .done_rise  (done_rise)
    );

    assign qual_edge = done_rise && (edge_cnt == SKIP_CNT);

    // Sequencer FSM with operand, result, counter and error registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            adder_a     <= '0;
            adder_b     <= '0;
            adder_cin   <= 1'b0;
            res_sum     <= '0;
            res_cout    <= 1'b0;
            edge_cnt    <= '0;
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        adder_a   <= in_a;
                        adder_b   <= in_b;
                        adder_cin <= in_cin;
                        edge_cnt  <= '0;
                        wd_cnt    <= '0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    wd_cnt <= wd_cnt + WD_W'(1);
                    // A qualifying edge in the watchdog's last cycle still wins.
                    if (qual_edge) begin
                        res_sum  <= adder_out;
                        res_cout <= adder_cout;
                        state    <= HOLD;
                    end else if (wd_cnt == WD_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else if (done_rise) begin
                        edge_cnt <= edge_cnt + EDGE_W'(1);
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign res_valid = (state == HOLD);

endmodule

// File: tb/tb_adder_b_sequencer.sv
// Directed scoreboard bench for adder_b_sequencer (TIMEOUT=16, SKIP_EDGES=1).
// Latency: n/a.
// Backpressure: exercised by holding res_ready low while a result is pending.
module tb_adder_b_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a, in_b;
    logic        in_cin;
    logic [15:0] adder_a, adder_b;
    logic        adder_cin;
    logic [15:0] adder_out;
    logic        adder_cout;
    logic        adder_done;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_sum;
    logic        res_cout;
    logic        busy;
    logic        timeout_err;

    int errors = 0;
    int checks = 0;
    int pops   = 0;
    logic [16:0] exp_q[$];

    always #5 clk = ~clk;

    // Behavioural stand-in for the adiabatic adder's combinational result.
    assign {adder_cout, adder_out} = {1'b0, adder_a} + {1'b0, adder_b} + {16'd0, adder_cin};

    adder_b_sequencer #(
        .WIDTH      (16),
        .SKIP_EDGES (1),
        .TIMEOUT    (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_cin      (in_cin),
        .adder_a     (adder_a),
        .adder_b     (adder_b),
        .adder_cin   (adder_cin),
        .adder_out   (adder_out),
        .adder_cout  (adder_cout),
        .adder_done  (adder_done),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_sum     (res_sum),
        .res_cout    (res_cout),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic c,
                         input logic [15:0] esum, input logic ecout, input bit expect_res);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = c;
        if (expect_res) exp_q.push_back({ecout, esum});
        tick();
        in_valid = 1'b0;
        in_a     = 16'hDEAD;
        in_b     = 16'hBEEF;
        in_cin   = ~c;
    endtask

    task automatic pulse_edge();
        adder_done = 1'b0;
        tick();
        adder_done = 1'b1;
        tick();
    endtask

    // Monitor: pop the scoreboard on every result handshake.
    always @(negedge clk) begin
        if (!reset && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got sum=%h cout=%b expected none", res_sum, res_cout);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                pops++;
                chk16("res_sum", res_sum, e[15:0]);
                chk1("res_cout", res_cout, e[16]);
            end
        end
    end

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_a       = '0;
        in_b       = '0;
        in_cin     = 1'b0;
        adder_done = 1'b0;
        res_ready  = 1'b1;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        chk1("rst_in_ready", in_ready, 1'b1);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_res_valid", res_valid, 1'b0);
        chk1("rst_timeout", timeout_err, 1'b0);
        chk16("rst_adder_a", adder_a, 16'h0000);
        chk16("rst_res_sum", res_sum, 16'h0000);

        // Basic add: first edge skipped, second captured
        issue(16'h1234, 16'h0FF0, 1'b1, 16'h2225, 1'b0, 1'b1);
        chk16("basic_adder_a", adder_a, 16'h1234);
        chk16("basic_adder_b", adder_b, 16'h0FF0);
        chk1("basic_adder_cin", adder_cin, 1'b1);
        chk1("basic_in_ready_low", in_ready, 1'b0);
        chk1("basic_busy", busy, 1'b1);
        pulse_edge();
        adder_done = 1'b0;
        tick();
        chk1("basic_skip_edge1", res_valid, 1'b0);
        adder_done = 1'b1;
        tick();
        chk1("basic_res_valid", res_valid, 1'b1);
        tick();
        chk1("basic_in_ready_back", in_ready, 1'b1);
        chk1("basic_res_valid_drop", res_valid, 1'b0);
        adder_done = 1'b0;
        tick();

        // Carry out, operands stable through WAIT while inputs wander
        issue(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1);
        for (int k = 0; k < 2; k++) begin
            pulse_edge();
            chk16("carry_a_stable", adder_a, 16'hFFFF);
            chk16("carry_b_stable", adder_b, 16'h0001);
            chk1("carry_cin_stable", adder_cin, 1'b0);
        end
        chk1("carry_res_valid", res_valid, 1'b1);
        adder_done = 1'b0;
        tick();

        // Done already high at accept: that level is not an edge
        adder_done = 1'b1;
        tick();
        issue(16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b1);
        tick();
        chk1("high_no_edge", res_valid, 1'b0);
        pulse_edge();
        adder_done = 1'b0;
        tick();
        chk1("high_one_edge_only", res_valid, 1'b0);
        adder_done = 1'b1;
        tick();
        chk1("high_capture", res_valid, 1'b1);
        adder_done = 1'b0;
        tick();

        // Back-pressure: result held for 10 cycles
        res_ready = 1'b0;
        issue(16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b1);
        pulse_edge();
        pulse_edge();
        adder_done = 1'b0;
        for (int k = 0; k < 10; k++) begin
            chk1("bp_res_valid", res_valid, 1'b1);
            chk1("bp_in_ready", in_ready, 1'b0);
            chk16("bp_res_sum", res_sum, 16'h1000);
            tick();
        end
        res_ready = 1'b1;
        tick();
        chk1("bp_release_in_ready", in_ready, 1'b1);

        // Timeout with done tied low
        issue(16'h0101, 16'h0202, 1'b0, 16'h0000, 1'b0, 1'b0);
        for (int k = 1; k < 16; k++) begin
            chk1("to_in_ready_low", in_ready, 1'b0);
            chk1("to_no_err_yet", timeout_err, 1'b0);
            chk1("to_no_res", res_valid, 1'b0);
            tick();
        end
        chk1("to_err_set", timeout_err, 1'b1);
        chk1("to_in_ready", in_ready, 1'b1);
        chk1("to_no_res_end", res_valid, 1'b0);

        // Normal op afterwards; sticky error survives
        issue(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b1);
        pulse_edge();
        pulse_edge();
        adder_done = 1'b0;
        tick();
        chk1("to_sticky", timeout_err, 1'b1);

        // Reset mid-WAIT after one edge
        issue(16'h5555, 16'h1111, 1'b0, 16'h0000, 1'b0, 1'b0);
        pulse_edge();
        adder_done = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk1("mid_in_ready", in_ready, 1'b1);
        chk1("mid_busy", busy, 1'b0);
        chk1("mid_res_valid", res_valid, 1'b0);
        chk1("mid_timeout_clr", timeout_err, 1'b0);
        chk16("mid_adder_a", adder_a, 16'h0000);
        chk16("mid_res_sum", res_sum, 16'h0000);
        chk1("mid_res_cout", res_cout, 1'b0);
        adder_done = 1'b1;
        repeat (3) tick();
        chk1("mid_no_result", res_valid, 1'b0);
        adder_done = 1'b0;
        tick();

        checks++;
        if (exp_q.size() != 0 || pops != 5) begin
            errors++;
            $display("FAIL scoreboard_drain: got pops=%0d left=%0d expected pops=5 left=0", pops, exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adder_b_sequencer.md
# adder_b_sequencer

Operation sequencer that sits between the ALU command source and the Bennett-clocked 16-bit adiabatic adder (`adder_b`). It accepts one add request per valid/ready handshake and holds the operands stable on the adder inputs for a complete Bennett cycle. It waits for a fresh `calculation_done` edge, captures `out`/`cout`, and presents the result on a valid/ready output port. A watchdog flags an adder that never completes.

## Interface
Parameters:
- `WIDTH`, 16: operand/result width; must match the adder.
- `SKIP_EDGES`, 1: number of done rising edges discarded after launch. These edges may belong to a Bennett cycle that started with stale operands.
- `TIMEOUT`, 1024: maximum cycles spent in WAIT before abort. Range 2..65535.

Ports:
- `clk`  in  1: single clock; the same clock drives the adder's Bennett generator.
- `reset`  in  1: synchronous, active-high.
- `in_valid`  in  1: request valid.
- `in_ready`  out  1: sequencer can accept a request.
- `in_a`, `in_b`  in  WIDTH: operands.
- `in_cin`  in  1: carry in.
- `adder_a`, `adder_b`  out  WIDTH: registered operands driven to the adder.
- `adder_cin`  out  1: registered carry driven to the adder.
- `adder_out`  in  WIDTH: adder sum.
- `adder_cout`  in  1: adder carry out.
- `adder_done`  in  1: adder `calculation_done`, treated as a level signal.
- `res_valid`  out  1: result valid.
- `res_ready`  in  1: consumer accepts the result.
- `res_sum`  out  WIDTH: captured sum.
- `res_cout`  out  1: captured carry out.
- `busy`  out  1: high whenever state ≠ IDLE.
- `timeout_err`  out  1: sticky watchdog flag.

## Operation
- States: IDLE, WAIT, HOLD.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`: latch `in_a`/`in_b`/`in_cin` into the operand registers, clear the edge counter and watchdog, go to WAIT.
- WAIT:
  - Rising edge is defined as `adder_done & ~done_q`. `done_q` is the registered `adder_done` and updates every cycle in every state.
  - Edges are counted only while in WAIT.
  - On edge number SKIP_EDGES+1: load `res_sum`←`adder_out` and `res_cout`←`adder_cout` from the same-cycle inputs, then go to HOLD.
  - Watchdog increments every WAIT cycle. When it reaches TIMEOUT-1 with no qualifying edge: set `timeout_err`, go to IDLE, and discard the request; no result is produced.
  - A qualifying edge in that same cycle wins: capture the result, do not set the error.
- HOLD:
  - `res_valid`=1.
  - On `res_ready`: go to IDLE.
  - Result registers hold their value until the next capture.
- Operand registers change only on an IDLE accept. They stay stable through WAIT and HOLD.
- Arithmetic is performed by the adder only; the sequencer adds no logic on the data path.
- `timeout_err` is cleared by reset only.
- Reset values:
  - State IDLE.
  - All operand and result registers 0.
  - `done_q`=0, counters 0.
  - `res_valid`=0, `busy`=0, `timeout_err`=0.
  - `in_ready`=1 from the first cycle after reset.
- Reset mid-operation: abandon the request without producing a result; all outputs take reset values on the next cycle.
- If `adder_done` is already high when WAIT is entered, that level is not an edge.

## Timing
- Accept handshake at cycle T: `adder_*` hold the new operands at T+1. `in_ready`=0 and `busy`=1 from T+1.
- An edge in cycle T itself is never counted.
- Qualifying edge at cycle E: `res_sum`/`res_cout` are valid and `res_valid`=1 at E+1.
- Result handshake at cycle R: `res_valid`=0 and `in_ready`=1 at R+1. The earliest next accept is R+1.
- Timeout abort: `timeout_err`=1 and `in_ready`=1 at T+TIMEOUT.
- All outputs are registered except `in_ready`, `busy` and `res_valid`, which decode the state register only.

## Structure
- Package `adiabatic_pkg` contains:
  - `seq_state_t` enum {IDLE, WAIT, HOLD}.
  - `ADDER_WIDTH`=16.
  - `BENNETT_WIDTH`=8.
- Sub-module `done_edge_detect`: registers `adder_done` and outputs the single-cycle rising-edge pulse. It is reset to 0.
- Edge counter and watchdog are local counters in the top module, sized `$clog2(SKIP_EDGES+2)` and `$clog2(TIMEOUT)`.

## Test plan
- **Basic add:** a=0x1234, b=0x0FF0, cin=1. Model adder_done rising twice → edge 1 ignored; after edge 2, res_sum=0x2225, res_cout=0, res_valid one cycle later.
- **Carry:** a=0xFFFF, b=0x0001, cin=0 → res_sum=0x0000, res_cout=1. Operands stay stable on `adder_a`/`adder_b` through all of WAIT.
- **Done already high:** adder_done high at accept and in the cycle after → not counted. Exactly two later rising edges are required before capture.
- **Back-pressure:** hold res_ready=0 for 10 cycles → res_valid stays 1, res_sum is unchanged, in_ready=0 throughout. Release → in_ready=1 the next cycle.
- **Timeout:** TIMEOUT=16, adder_done tied 0 → timeout_err=1 and in_ready=1 exactly 16 cycles after accept, with no res_valid. Then confirm the error is still 1 after a normal completed operation.
- **Reset mid-WAIT:** assert reset after one edge → next cycle state IDLE, outputs 0, res_valid never asserted.
